// File: rtl/view_pkg.sv
// Shared types and screen geometry for the pixel write path into the
// double-buffered frame buffer.
package view_pkg;

  localparam int SCREEN_W   = 320;
  localparam int SCREEN_H   = 240;
  localparam int COLOR_W    = 12;
  localparam int ADDR_W     = 17;
  localparam int FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    WAIT_VS,
    SWAP
  } swap_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] colour;
  } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO of pixels: the head entry is visible on
// o_head whenever o_empty is low.
module pixel_fifo
  import view_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  pixel_t                   i_push_data,
  input  logic                     i_pop,
  output pixel_t                   o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  pixel_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: storage is deliberately not reset; the pointers and count alone
  // define which entries are live, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_buffer.sv
// Clips and addresses compositor pixels, queues them for the frame-buffer
// write port, and swaps front/back buffers only at vsync after a full drain.
module pixel_write_buffer
  import view_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic [8:0]          pix_x,
  input  logic [7:0]          pix_y,
  input  logic [COLOR_W-1:0]  pix_color,
  input  logic                pix_we,
  output logic                pix_ready,
  input  logic                swap_req,
  input  logic                vsync,
  output logic [ADDR_W:0]     mem_addr,
  output logic [COLOR_W-1:0]  mem_data,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic                front_buf,
  output logic                busy,
  output logic                overflow,
  output logic [15:0]         clip_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);

  swap_state_e        r_state;
  swap_state_e        w_next_state;
  logic               r_front_buf;
  logic               r_overflow;
  logic [15:0]        r_clip_count;
  logic               r_s1_valid;
  pixel_t             r_s1_pix;

  logic               w_accept;
  logic               w_in_range;
  logic [ADDR_W-1:0]  w_addr;
  logic [ADDR_W-1:0]  w_y_ext;
  logic [CNT_W-1:0]   w_occupancy;
  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  pixel_t             w_head;
  logic               w_idle;
  logic               w_toggle;

  // y*320 expressed as y*256 + y*64 so no multiplier is needed.
  assign w_y_ext     = ADDR_W'(pix_y);
  assign w_addr      = (w_y_ext << 8) + (w_y_ext << 6) + ADDR_W'(pix_x);
  assign w_in_range  = (pix_x < X_LIMIT) && (pix_y < Y_LIMIT);
  assign w_occupancy = w_fifo_count + CNT_W'(r_s1_valid);
  assign pix_ready   = w_idle && (w_occupancy < CNT_W'(FIFO_DEPTH));
  assign w_accept    = pix_we && pix_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid   <= 1'b0;
      r_s1_pix     <= '0;
      r_clip_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_s1_valid <= w_accept && w_in_range;
      if (w_accept && w_in_range) begin
        r_s1_pix.addr   <= w_addr;
        r_s1_pix.colour <= pix_color;
      end
      if (w_accept && !w_in_range && (r_clip_count != 16'hFFFF))
        r_clip_count <= r_clip_count + 16'd1;
      if (pix_we && !pix_ready)
        r_overflow <= 1'b1;
    end
  end

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (r_s1_valid && !w_fifo_full),
    .i_push_data (r_s1_pix),
    .i_pop       (mem_we && mem_ready),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: next state defaults to the current state before the case so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (swap_req) w_next_state = DRAIN;
      DRAIN:   if (!r_s1_valid && w_fifo_empty) w_next_state = WAIT_VS;
      WAIT_VS: if (vsync) w_next_state = SWAP;
      SWAP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_idle   = (r_state == IDLE);
    w_toggle = (r_state == SWAP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_front_buf <= 1'b0;
    else if (w_toggle) r_front_buf <= ~r_front_buf;
  end

  // Address and data read as zero whenever no write is pending.
  assign mem_we     = !w_fifo_empty;
  assign mem_addr   = w_fifo_empty ? '0 : {~r_front_buf, w_head.addr};
  assign mem_data   = w_fifo_empty ? '0 : w_head.colour;
  assign front_buf  = r_front_buf;
  assign overflow   = r_overflow;
  assign clip_count = r_clip_count;
  assign busy       = !w_idle || !w_fifo_empty || r_s1_valid;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Self-checking bench: expected frame-buffer writes come from a queue of
// {buffer, y*320+x, colour} built from the pixels the bench offers.
module tb_pixel_write_buffer;

  typedef struct {
    logic [17:0] addr;
    logic [11:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic [11:0] pix_color;
  logic        pix_we;
  logic        pix_ready;
  logic        swap_req;
  logic        vsync;
  logic [17:0] mem_addr;
  logic [11:0] mem_data;
  logic        mem_we;
  logic        mem_ready;
  logic        front_buf;
  logic        busy;
  logic        overflow;
  logic [15:0] clip_count;

  int  n_vec = 0;
  int  n_err = 0;
  wr_t exp_q[$];
  logic m_front, m_idle, m_ovf;
  int   m_clip;

  logic        stall_prev;
  logic [17:0] prev_addr;
  logic [11:0] prev_data;

  pixel_write_buffer dut (
    .clk        (clk),
    .resetn     (resetn),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .pix_we     (pix_we),
    .pix_ready  (pix_ready),
    .swap_req   (swap_req),
    .vsync      (vsync),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .front_buf  (front_buf),
    .busy       (busy),
    .overflow   (overflow),
    .clip_count (clip_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_ready();
    return m_idle && (exp_q.size() < 16);
  endfunction

  // Offer one pixel for one cycle and update the reference model.
  task automatic send(input int x, input int y, input logic [11:0] c);
    logic r;
    pix_x = 9'(x); pix_y = 8'(y); pix_color = c; pix_we = 1'b1;
    r = exp_ready();
    check("pix_ready", 32'(pix_ready), 32'(r));
    if (r) begin
      if (x < 320 && y < 240) exp_q.push_back('{{~m_front, 17'(y * 320 + x)}, c});
      else if (m_clip != 65535) m_clip++;
    end else begin
      m_ovf = 1'b1;
    end
    step();
    pix_we = 1'b0;
  endtask

  task automatic idle_cycle();
    pix_we = 1'b0;
    check("pix_ready_idle", 32'(pix_ready), 32'(exp_ready()));
    step();
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  // Write-port monitor: every accepted write must match the model's oldest
  // entry, and a stalled write must hold address and data.
  always @(negedge clk) begin
    if (!resetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && mem_we) begin
        check("hold_addr", 32'(mem_addr), 32'(prev_addr));
        check("hold_data", 32'(mem_data), 32'(prev_data));
      end
      if (mem_we && mem_ready) begin
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("mem_addr", 32'(mem_addr), 32'(e.addr));
          check("mem_data", 32'(mem_data), 32'(e.data));
        end
      end
      stall_prev = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_data;
    end
  end

  initial begin
    int sent;
    logic [15:0] clip_before;
    resetn = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0; pix_we = 1'b0;
    swap_req = 1'b0; vsync = 1'b0; mem_ready = 1'b1;
    m_front = 1'b0; m_idle = 1'b1; m_ovf = 1'b0; m_clip = 0;
    stall_prev = 1'b0; prev_addr = '0; prev_data = '0;
    #23;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_front_buf", 32'(front_buf), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_clip", 32'(clip_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    step();
    resetn = 1'b1;
    step();
    check("rst_pix_ready", 32'(pix_ready), 32'd1);

    // Single pixel latency: accepted in cycle 0, written in cycle 2 only.
    send(5, 2, 12'hF00);
    check("lat_c1_we", 32'(mem_we), 32'd0);
    step();
    check("lat_c2_we", 32'(mem_we), 32'd1);
    check("lat_c2_addr", 32'(mem_addr), 32'h20285);
    check("lat_c2_data", 32'(mem_data), 32'hF00);
    step();
    check("lat_c3_we", 32'(mem_we), 32'd0);

    // Clipping boundaries.
    send(320, 0, 12'h0A0);
    send(0, 240, 12'h00B);
    step(); step();
    check("clip_no_write", 32'(mem_we), 32'd0);
    check("clip_count2", 32'(clip_count), 32'd2);
    send(319, 239, 12'h5A5);
    wait_drain(10);

    // Back-pressure: 20 attempts with the port stalled, only 16 fit.
    mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (exp_ready()) send(i * 7, i, 12'(i + 12'h100));
      else idle_cycle();
    end
    check("bp_ready_low", 32'(pix_ready), 32'd0);
    check("bp_no_overflow", 32'(overflow), 32'd0);
    mem_ready = 1'b1;
    wait_drain(40);

    // Protocol violation: pix_we held while the buffer is full.
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(i, 100, 12'(i));
    step(); step();
    send(1, 1, 12'hBAD);
    send(2, 2, 12'hBAD);
    check("ovf_set", 32'(overflow), 32'(m_ovf));
    mem_ready = 1'b1;
    wait_drain(40);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Swap: queued pixels land in the old back buffer, then wait for vsync.
    mem_ready = 1'b0;
    send(10, 10, 12'h111); send(11, 10, 12'h222); send(12, 10, 12'h333);
    step(); step();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    m_idle = 1'b0;
    check("drain_ready", 32'(pix_ready), 32'd0);
    check("drain_busy", 32'(busy), 32'd1);
    mem_ready = 1'b1;
    wait_drain(20);
    step(); step(); step();
    check("wvs_ready", 32'(pix_ready), 32'd0);
    check("wvs_front", 32'(front_buf), 32'd0);
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    check("swap_front_pending", 32'(front_buf), 32'd0);
    step();
    m_front = 1'b1; m_idle = 1'b1;
    check("swap_front", 32'(front_buf), 32'(m_front));
    check("swap_ready", 32'(pix_ready), 32'd1);
    send(7, 3, 12'h0F0);
    wait_drain(10);

    // swap_req with vsync in IDLE, and vsync while DRAIN completes: both missed.
    swap_req = 1'b1; vsync = 1'b1;
    step();
    swap_req = 1'b0;
    step();
    vsync = 1'b0;
    m_idle = 1'b0;
    step(); step(); step();
    check("missed_vs_front", 32'(front_buf), 32'(m_front));
    check("missed_vs_ready", 32'(pix_ready), 32'd0);
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    m_front = 1'b0; m_idle = 1'b1;
    check("second_swap_front", 32'(front_buf), 32'(m_front));

    // vsync in IDLE does nothing.
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step(); step();
    check("idle_vs_front", 32'(front_buf), 32'(m_front));
    check("idle_vs_ready", 32'(pix_ready), 32'd1);

    // Randomized traffic with a randomly stalling memory port.
    sent = 0;
    for (int i = 0; i < 400; i++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 6 && exp_ready()) begin
        send(int'($urandom_range(0, 335)), int'($urandom_range(0, 250)), 12'($urandom));
        sent++;
      end else begin
        idle_cycle();
      end
    end
    mem_ready = 1'b1;
    wait_drain(40);
    check("rand_clip", 32'(clip_count), 32'(m_clip));
    check("rand_overflow", 32'(overflow), 32'(m_ovf));
    check("rand_busy", 32'(busy), 32'd0);

    // Reset mid-drain discards everything immediately.
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(i + 50, 20, 12'(i + 12'h300));
    step(); step();
    check("pre_rst_we", 32'(mem_we), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    exp_q.delete();
    m_front = 1'b0; m_idle = 1'b1; m_ovf = 1'b0; m_clip = 0;
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_front", 32'(front_buf), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_clip", 32'(clip_count), 32'd0);
    mem_ready = 1'b1;
    step(); step();
    resetn = 1'b1;
    step();
    check("post_rst_ready", 32'(pix_ready), 32'd1);
    check("post_rst_we", 32'(mem_we), 32'd0);
    clip_before = clip_count;
    check("post_rst_clip", 32'(clip_before), 32'd0);
    send(100, 200, 12'hC3C);
    wait_drain(10);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pixel_write_buffer.md
Name: pixel_write_buffer

Overview:
- Sits directly downstream of the game view compositor and consumes its per-pixel stream: X, Y, 12-bit colour and write enable.
- Range-checks each pixel and converts it to a linear frame-buffer address.
- Buffers pixels in a small FIFO and drains them to the frame-buffer memory write port using a ready handshake.
- Manages double-buffer swaps, synchronised to the scan-out vsync, so partially drawn frames are never displayed.

Parameters:
- SCREEN_W, 320, visible width in pixels.
- SCREEN_H, 240, visible height in pixels.
- COLOR_W, 12, colour width (4:4:4).
- ADDR_W, 17, per-buffer pixel address width (320*240 = 76800 < 2^17).
- FIFO_DEPTH, 16, pixel FIFO entries (power of two).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pix_x  in  9  pixel column.
- pix_y  in  8  pixel row.
- pix_color  in  COLOR_W  pixel colour.
- pix_we  in  1  pixel valid.
- pix_ready  out  1  block can accept a pixel this cycle.
- swap_req  in  1  one-cycle pulse: current back-buffer frame complete.
- vsync  in  1  one-cycle pulse from scan-out at start of vertical blank.
- mem_addr  out  ADDR_W+1  {buffer select, y*SCREEN_W+x}.
- mem_data  out  COLOR_W  pixel colour to memory.
- mem_we  out  1  write request.
- mem_ready  in  1  memory accepts the write this cycle.
- front_buf  out  1  buffer currently scanned out; the back buffer is ~front_buf.
- busy  out  1  state != IDLE, or FIFO/stage-1 non-empty.
- overflow  out  1  sticky protocol-violation flag.
- clip_count  out  16  saturating count of out-of-range pixels dropped.

Behaviour:
- Reset: front_buf=0, overflow=0, clip_count=0, mem_we=0, mem_addr=0, mem_data=0, FIFO empty, stage-1 invalid, state IDLE. Reset mid-operation discards all buffered pixels with no partial write.
- Accept: a pixel is accepted when pix_we && pix_ready.
- pix_ready is combinational: (state==IDLE) && (fifo_count + stage1_valid < FIFO_DEPTH).
- pix_we while pix_ready=0: pixel ignored, overflow set. overflow clears only on reset.
- Stage 1 (registered): on accept, if pix_x<SCREEN_W and pix_y<SCREEN_H, store addr=(pix_y<<8)+(pix_y<<6)+pix_x (17-bit, no truncation) and colour, and set stage1_valid. Otherwise drop the pixel and increment clip_count, saturating at 0xFFFF.
- Stage 2: a valid stage-1 entry is pushed into the FIFO on the next cycle.
- Latency: pixel accepted in cycle N gives earliest mem_we=1 in cycle N+2.
- FIFO is show-ahead. mem_we = !fifo_empty. mem_addr={~front_buf, head.addr}. mem_data=head.colour.
- Handshake: pop on mem_we && mem_ready. While mem_we=1 and mem_ready=0, mem_addr and mem_data hold stable.
- Simultaneous push and pop: count unchanged. Ordering is strictly FIFO.
- Swap FSM:
  - IDLE: swap_req -> DRAIN.
  - DRAIN: stage1 empty && FIFO empty -> WAIT_VS.
  - WAIT_VS: vsync -> SWAP.
  - SWAP: toggle front_buf (one cycle) -> IDLE.
- swap_req outside IDLE is ignored. vsync outside WAIT_VS is ignored.
- swap_req and vsync in the same IDLE cycle: go to DRAIN; that vsync does not count.
- If DRAIN completes in the same cycle that vsync arrives, the vsync is missed and the FSM waits for the next one.
- pix_ready=0 in DRAIN, WAIT_VS and SWAP. Pixels accepted before swap_req are written to the old back buffer.

Decomposition:
- Package view_pkg holds: SCREEN_W, SCREEN_H, COLOR_W, ADDR_W, the swap-state enum (IDLE, DRAIN, WAIT_VS, SWAP), and a pixel struct {addr, colour}.
- Sub-module pixel_fifo: a synchronous show-ahead FIFO with push, pop, full, empty and count, reset asynchronously by resetn.
- Address calculation, clipping, swap FSM and counters live in pixel_write_buffer.

Test Plan:
- Single pixel, mem_ready=1: x=5, y=2, colour=0xF00 in cycle 0 -> cycle 2: mem_we=1, mem_addr=0x20285 ({1,645}), mem_data=0xF00; mem_we=0 in cycle 3.
- Clipping: x=320,y=0 then x=0,y=240 -> no mem_we; clip_count=2. x=319,y=239 -> mem_addr low bits=76799.
- Back-pressure: 20 back-to-back pixels with mem_ready=0 -> pix_ready drops after 16 accepted; overflow stays 0. Release mem_ready -> 16 writes in order with exact addresses.
- Protocol violation: hold pix_we=1 while pix_ready=0 -> overflow=1 and stays set until resetn pulses low.
- Swap: 3 pixels queued, mem_ready=0, swap_req pulse -> state DRAIN, pix_ready=0. Release mem_ready -> 3 writes with buffer bit 1, then WAIT_VS. vsync -> front_buf=1 one cycle later; next pixel written with buffer bit 0.
- Reset mid-drain: 8 pixels queued, assert resetn low -> mem_we=0 immediately, front_buf=0, FIFO empty, pix_ready=1 after release.
